operand_issuer: RTL and testbench

OPERAND_ISSUER -- requirements
Module: operand_issuer

---
 rtl/operand_issuer.sv | 100 ++++++++++
 tb/tb_operand_issuer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_issuer.sv
// Operand issuer: registers accepted operand pairs onto the datapath, tracks them through
// a fixed-latency pipe and buffers the returning results, with credit-based flow control.
module operand_issuer #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_opa,
  input  logic [31:0] in_opb,
  output logic [31:0] opa,
  output logic [31:0] opb,
  output logic        op_valid,
  input  logic [31:0] dp_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [1:0]  res_signs
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + LATENCY + 2) + 1;

  logic                    r_op_valid;
  logic [31:0]             r_opa;
  logic [31:0]             r_opb;
  logic [LATENCY-1:0]      r_vsr;
  logic [LATENCY-1:0][1:0] r_tsr;
  logic [33:0]             r_mem [DEPTH];
  logic [AW-1:0]           r_wptr;
  logic [AW-1:0]           r_rptr;
  logic [AW:0]             r_count;
  logic                    r_rdy_en;

  logic                    w_accept;
  logic                    w_push;
  logic                    w_pop;
  logic [CW-1:0]           w_outstanding;

  // Credit counts every operation not yet handed to the consumer, so the FIFO can never overflow.
  always_comb begin
    w_outstanding = CW'(r_count) + CW'(r_op_valid);
    for (int unsigned i = 0; i < LATENCY; i++) begin
      w_outstanding = w_outstanding + CW'(r_vsr[i]);
    end
  end

  assign in_ready  = r_rdy_en && (w_outstanding < CW'(DEPTH));
  assign w_accept  = in_valid && in_ready;
  assign w_push    = r_vsr[LATENCY-1];
  assign res_valid = (r_count != '0);
  assign w_pop     = res_valid && res_ready;

  assign op_valid  = r_op_valid;
  assign opa       = r_opa;
  assign opb       = r_opb;
  assign res_data  = r_mem[r_rptr][31:0];
  assign res_signs = r_mem[r_rptr][33:32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en   <= 1'b0;
      r_op_valid <= 1'b0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_vsr      <= '0;
      r_tsr      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_rdy_en   <= 1'b1;
      r_op_valid <= w_accept;
      if (w_accept) begin
        r_opa <= in_opa;
        r_opb <= in_opb;
      end
      r_vsr[0] <= r_op_valid;
      r_tsr[0] <= {r_opa[31], r_opb[31]};
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_vsr[i] <= r_vsr[i-1];
        r_tsr[i] <= r_tsr[i-1];
      end
      if (w_push) begin
        r_mem[r_wptr] <= {r_tsr[LATENCY-1], dp_out};
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: tb/tb_operand_issuer.sv
// Directed and randomised bench for operand_issuer with a fixed-latency XOR datapath model
// and an in-order result scoreboard.
module tb_operand_issuer;

  localparam int unsigned L = 2;
  localparam int unsigned D = 4;
  localparam logic [31:0] K = 32'h9234_567B;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_opa = '0;
  logic [31:0] in_opb = '0;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        op_valid;
  logic [31:0] dp_out = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [1:0]  res_signs;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_pops   = 0;
  int unsigned garb     = 0;
  logic [33:0] sb [$];
  logic [31:0] h [0:L];

  logic [31:0] va [8] = '{32'h8000_0001, 32'h0000_0005, 32'hFFFF_0000, 32'h7FFF_FFFF,
                          32'h8000_0000, 32'h1234_0000, 32'hC0DE_0001, 32'h0000_0000};
  logic [31:0] vb [8] = '{32'h0000_0002, 32'h8000_0006, 32'hF000_000F, 32'h0000_0001,
                          32'h8000_0000, 32'h0000_4321, 32'h0BAD_F00D, 32'hFFFF_FFFF};

  operand_issuer #(.LATENCY(L), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opa(in_opa), .in_opb(in_opb), .opa(opa), .opb(opb), .op_valid(op_valid),
    .dp_out(dp_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_signs(res_signs)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a, input logic [31:0] b);
    return a ^ b ^ K;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One cycle: drive inputs at the negedge, score handshakes, advance to the next negedge.
  task automatic cyc(input logic iv, input logic [31:0] a, input logic [31:0] b,
                     input logic rr, output logic acc);
    logic pop;
    in_valid  = iv;
    in_opa    = a;
    in_opb    = b;
    res_ready = rr;
    acc = iv && in_ready;
    pop = res_valid && rr;
    if (acc) sb.push_back({a[31], b[31], f(a, b)});
    if (pop) begin
      n_pops++;
      check("pop_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) check("result", {res_signs, res_data}, sb.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Datapath model: result appears on dp_out exactly L cycles after op_valid.
  initial begin : dp_model
    for (int i = 0; i <= int'(L); i++) h[i] = '0;
    forever begin
      @(negedge clk);
      for (int i = int'(L); i > 0; i--) h[i] = h[i-1];
      h[0] = op_valid ? f(opa, opb) : (32'hBAD0_0000 | garb);
      garb++;
      dp_out = h[L];
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic acc;
    int unsigned k, guard, p0;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_op_valid", op_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_signs", res_signs, 0);
    check("rst_opa", opa, 0);
    check("rst_opb", opb, 0);
    rst_n = 1'b1;
    #1 check("rdy_before_edge", in_ready, 0);
    @(negedge clk);
    check("rdy_after_edge", in_ready, 1);

    // Single operation, cycle-exact
    in_valid = 1'b1; in_opa = 32'h8000_0001; in_opb = 32'h0000_0002; res_ready = 1'b1;
    check("c0_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; in_opa = 32'hFFFF_FFFF; in_opb = 32'hFFFF_FFFF;
    check("c1_op_valid", op_valid, 1);
    check("c1_opa", opa, 32'h8000_0001);
    check("c1_opb", opb, 32'h0000_0002);
    @(negedge clk);
    check("c2_op_valid", op_valid, 0);
    check("c2_opa_hold", opa, 32'h8000_0001);
    check("c2_opb_hold", opb, 32'h0000_0002);
    check("c2_res_valid", res_valid, 0);
    @(negedge clk);
    check("c3_res_valid", res_valid, 0);
    @(negedge clk);
    check("c4_res_valid", res_valid, 1);
    check("c4_res_data", res_data, 32'h1234_5678);
    check("c4_res_signs", res_signs, 2'b10);
    @(negedge clk);
    check("c5_res_valid", res_valid, 0);

    // Back-to-back eight operations with consumer always ready
    k = 0; guard = 0; p0 = n_pops;
    while (k < 8 && guard < 100) begin
      cyc(1'b1, va[k], vb[k], 1'b1, acc);
      if (acc) k++;
      guard++;
    end
    check("b2b_accepts", k, 8);
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      cyc(1'b0, '0, '0, 1'b1, acc);
      guard++;
    end
    check("b2b_drain", sb.size(), 0);
    check("b2b_pops", n_pops - p0, 8);

    // Consumer stall: exactly D accepts, then credit exhausted
    k = 0;
    repeat (12) begin
      cyc(1'b1, va[k], vb[k], 1'b0, acc);
      if (acc) k++;
    end
    check("stall_accepts", k, D);
    check("stall_ready", in_ready, 0);
    check("stall_res_valid", res_valid, 1);
    p0 = n_pops;
    cyc(1'b0, '0, '0, 1'b1, acc);
    check("ready_after_pop", in_ready, 1);
    repeat (3) cyc(1'b0, '0, '0, 1'b1, acc);
    check("stall_pops", n_pops - p0, D);
    check("stall_empty", res_valid, 0);

    // Fill, then push and pop concurrently near full occupancy
    k = 0; guard = 0;
    while (k < D && guard < 20) begin
      cyc(1'b1, va[k+2], vb[k+2], 1'b0, acc);
      if (acc) k++;
      guard++;
    end
    repeat (6) cyc(1'b0, '0, '0, 1'b0, acc);
    for (int i = 0; i < 16; i++) cyc(1'b1, va[i % 8], vb[(i + 3) % 8], 1'(i % 3 != 2), acc);
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      cyc(1'b0, '0, '0, 1'b1, acc);
      guard++;
    end
    check("mix_drain", sb.size(), 0);

    // Reset with two results buffered and two in flight
    for (int i = 0; i < 4; i++) cyc(1'b1, va[i], vb[i], 1'b0, acc);
    cyc(1'b0, '0, '0, 1'b0, acc);
    check("pre_rst_res_valid", res_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_res_valid", res_valid, 0);
    check("rst_mid_op_valid", op_valid, 0);
    check("rst_mid_in_ready", in_ready, 0);
    sb.delete();
    in_valid = 1'b0; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_stale_result", res_valid, 0);
    end

    // Random traffic against the scoreboard
    repeat (10000) cyc(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)), acc);
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      cyc(1'b0, '0, '0, 1'b1, acc);
      guard++;
    end
    check("rand_drain", sb.size(), 0);
    check("rand_empty", res_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
